// File: rtl/mul_array_arbiter_pkg.sv
// Shared field/array constants, lane helpers and FSM state type for the
// GF(2^m) multiplier-array arbiter.
package mul_array_arbiter_pkg;

  localparam int M       = 16;          // field element width
  localparam int LANES   = 9;           // multiplier lanes
  localparam int MUL_LAT = 1;           // operand register -> mul_r_dat
  localparam int VEC_W   = LANES * M;   // one full operand vector

  typedef logic [VEC_W-1:0] lane_vec_t;
  typedef logic [M-1:0]     elem_t;
  typedef logic [1:0]       req_id_t;   // wide enough for up to 4 requesters

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Lane 0 sits at the MSB end so lane i maps to mul(i+1).
  function automatic elem_t lane_get(input lane_vec_t vec, input int i);
    return vec[(LANES-1-i)*M +: M];
  endfunction

  function automatic lane_vec_t lane_set(input lane_vec_t vec, input int i,
                                         input elem_t val);
    lane_vec_t r;
    r = vec;
    r[(LANES-1-i)*M +: M] = val;
    return r;
  endfunction

endpackage

// File: rtl/mul_array_arbiter_if.sv
// Requester-side and array-side signals of the arbiter. master = the
// requesters plus multiplier array, slave = the arbiter itself.
interface mul_array_arbiter_if #(
  parameter int NREQ = 3
);
  import mul_array_arbiter_pkg::*;

  // requester side; operand slice k belongs to requester k
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             lock;
  logic [NREQ-1:0][VEC_W-1:0]  o_in;
  logic [NREQ-1:0][VEC_W-1:0]  t_in;
  logic [NREQ-1:0][VEC_W-1:0]  add_in;
  logic [NREQ-1:0]             gnt;
  logic                        busy;
  logic [NREQ-1:0]             rsp_valid;
  lane_vec_t                   rsp_dat;

  // array side
  lane_vec_t                   mul_o_out;
  lane_vec_t                   mul_t_out;
  lane_vec_t                   mul_add_out;
  lane_vec_t                   mul_r_dat;

  modport master (
    output req, lock, o_in, t_in, add_in, mul_r_dat,
    input  gnt, busy, rsp_valid, rsp_dat, mul_o_out, mul_t_out, mul_add_out
  );

  modport slave (
    input  req, lock, o_in, t_in, add_in, mul_r_dat,
    output gnt, busy, rsp_valid, rsp_dat, mul_o_out, mul_t_out, mul_add_out
  );

endinterface

// File: rtl/mul_array_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after
// i_ptr wins. i_mask restricts eligibility (used while a burst holds a lock).
module rr_arbiter
  import mul_array_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_mask,
  input  req_id_t         i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output req_id_t         o_id,
  output logic            o_any
);

  logic [NREQ-1:0] w_elig;

  assign w_elig = i_req & i_mask;

  // Scan from the pointer, wrapping, and stop at the first eligible request.
  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    o_any = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      req_id_t w_idx;
      w_idx = req_id_t'((int'(i_ptr) + off) % NREQ);
      if (!o_any && w_elig[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
      end
    end
  end

endmodule

// File: rtl/mul_array_arbiter.sv
// Shares the 9-lane GF(2^m) multiplier array between NREQ requesters:
// round-robin (or locked) grant, registered operand issue, and a tag
// pipeline that routes each result back to its owner 1+MUL_LAT cycles later.
module mul_array_arbiter
  import mul_array_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  mul_array_arbiter_if.slave      bus
);

  arb_state_t                  r_state, w_state_nxt;
  req_id_t                     r_owner, w_owner_nxt;
  req_id_t                     r_ptr,   w_ptr_nxt;

  logic [NREQ-1:0]             w_mask;
  logic [NREQ-1:0]             w_arb_gnt;
  logic [NREQ-1:0]             w_gnt;
  req_id_t                     w_id;
  logic                        w_any;
  logic                        w_issue;

  lane_vec_t                   r_mul_o, r_mul_t, r_mul_add;
  // stage 0 is aligned with the operand registers; stage MUL_LAT with mul_r_dat
  logic [MUL_LAT:0][NREQ-1:0]  r_tag;
  logic                        w_tag_any;

  // Locked: only the owner may be granted. Kept out of the FSM block so the
  // arbiter output feeding next-state logic does not form a block-level loop.
  always_comb begin
    w_mask = '1;
    if (r_state == ST_LOCKED) begin
      w_mask          = '0;
      w_mask[r_owner] = 1'b1;
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req  (bus.req),
    .i_mask (w_mask),
    .i_ptr  (r_ptr),
    .o_gnt  (w_arb_gnt),
    .o_id   (w_id),
    .o_any  (w_any)
  );

  // No grant can be accepted while reset is held.
  assign w_gnt   = rst ? '0 : w_arb_gnt;
  assign w_issue = w_any & ~rst;
  assign bus.gnt = w_gnt;

  // FSM state, lock owner and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OPEN;
      r_owner <= '0;   // meaningful only in ST_LOCKED, so 0 stands for "none"
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state: a locked grant enters LOCKED; dropping lock releases at the
  // edge and moves the pointer past the owner. The pointer is frozen while locked.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_OPEN: begin
        if (w_any) begin
          w_ptr_nxt = req_id_t'((int'(w_id) + 1) % NREQ);
          if (bus.lock[w_id]) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_id;
          end
        end
      end
      ST_LOCKED: begin
        if (!bus.lock[r_owner]) begin
          w_state_nxt = ST_OPEN;
          w_ptr_nxt   = req_id_t'((int'(r_owner) + 1) % NREQ);
        end
      end
      default: w_state_nxt = ST_OPEN;
    endcase
  end

  // Operand registers: the granted slice is captured, idle cycles load zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_o   <= '0;
      r_mul_t   <= '0;
      r_mul_add <= '0;
    end else if (w_issue) begin
      r_mul_o   <= bus.o_in[w_id];
      r_mul_t   <= bus.t_in[w_id];
      r_mul_add <= bus.add_in[w_id];
    end else begin
      r_mul_o   <= '0;
      r_mul_t   <= '0;
      r_mul_add <= '0;
    end
  end

  // Owner tag shift register; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= w_gnt;
      for (int i = 1; i <= MUL_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tag_any       = |r_tag;
  assign bus.busy        = (r_state == ST_LOCKED) | w_tag_any;
  assign bus.rsp_valid   = r_tag[MUL_LAT];
  assign bus.rsp_dat     = bus.mul_r_dat;
  assign bus.mul_o_out   = r_mul_o;
  assign bus.mul_t_out   = r_mul_t;
  assign bus.mul_add_out = r_mul_add;

endmodule

// File: tb/tb_mul_array_arbiter.sv
// Directed bench for mul_array_arbiter with a scoreboard of expected
// responses and a behavioural stand-in for the multiplier array.
module tb_mul_array_arbiter;
  import mul_array_arbiter_pkg::*;

  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  typedef struct {
    int              due;
    logic [NREQ-1:0] vld;
    lane_vec_t       dat;
  } exp_t;

  exp_t q[$];
  logic [3*VEC_W-1:0] exp_ops = '0;   // operands expected in the register next cycle

  mul_array_arbiter_if #(.NREQ(NREQ)) bus ();

  mul_array_arbiter #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Array stand-in: per lane (o*t mod 2^16) ^ add, one cycle after operands.
  function automatic lane_vec_t arr_f(input lane_vec_t o, input lane_vec_t t,
                                      input lane_vec_t a);
    lane_vec_t r;
    elem_t     p;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      p = lane_get(o, i) * lane_get(t, i);
      r = lane_set(r, i, p ^ lane_get(a, i));
    end
    return r;
  endfunction

  initial bus.mul_r_dat = '0;
  always @(posedge clk) bus.mul_r_dat <= arr_f(bus.mul_o_out, bus.mul_t_out, bus.mul_add_out);

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every cycle either the scheduled response or silence.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", 512'(bus.rsp_valid), 512'(q[0].vld));
      chk("rsp_dat",   512'(bus.rsp_dat),   512'(q[0].dat));
      void'(q.pop_front());
    end else begin
      chk("rsp_idle", 512'(bus.rsp_valid), 512'(0));
    end
  end

  task automatic rand_ops();
    for (int k = 0; k < NREQ; k++)
      for (int i = 0; i < LANES; i++) begin
        bus.o_in[k]   = lane_set(bus.o_in[k],   i, elem_t'($urandom_range(0, 65535)));
        bus.t_in[k]   = lane_set(bus.t_in[k],   i, elem_t'($urandom_range(0, 65535)));
        bus.add_in[k] = lane_set(bus.add_in[k], i, elem_t'($urandom_range(0, 65535)));
      end
  endtask

  // One cycle: inputs already applied; check grant/operands/busy mid-cycle,
  // schedule the response for a grant, then advance past the next edge.
  task automatic step(input string tag, input logic [NREQ-1:0] r,
                      input logic [NREQ-1:0] l, input logic [NREQ-1:0] eg,
                      input bit cb = 1'b0, input logic eb = 1'b0);
    int k;
    bus.req  = r;
    bus.lock = l;
    @(negedge clk);
    chk({tag, ":gnt"}, 512'(bus.gnt), 512'(eg));
    chk({tag, ":ops"}, 512'({bus.mul_o_out, bus.mul_t_out, bus.mul_add_out}), 512'(exp_ops));
    if (cb) chk({tag, ":busy"}, 512'(bus.busy), 512'(eb));
    k = -1;
    for (int j = 0; j < NREQ; j++) if (eg[j]) k = j;
    if (k >= 0) begin
      exp_ops = {bus.o_in[k], bus.t_in[k], bus.add_in[k]};
      q.push_back('{cyc + 2, eg, arr_f(bus.o_in[k], bus.t_in[k], bus.add_in[k])});
    end else begin
      exp_ops = '0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req = '0; bus.lock = '0;
    bus.o_in = '0; bus.t_in = '0; bus.add_in = '0;
    rand_ops();
    repeat (2) @(posedge clk);
    #1;
    // reset state, still in reset
    chk("rst_gnt",  512'(bus.gnt), 512'(0));
    chk("rst_busy", 512'(bus.busy), 512'(0));
    chk("rst_ops",  512'({bus.mul_o_out, bus.mul_t_out, bus.mul_add_out}), 512'(0));
    chk("rst_rsp",  512'(bus.rsp_valid), 512'(0));
    rst = 1'b0;

    // idle: nothing granted, nothing busy
    for (int i = 0; i < 10; i++) step("idle", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);

    // round robin from pointer 0
    rand_ops(); step("rr0", 3'b111, 3'b000, 3'b001);
    rand_ops(); step("rr1", 3'b111, 3'b000, 3'b010);
    rand_ops(); step("rr2", 3'b111, 3'b000, 3'b100);
    rand_ops(); step("rr3", 3'b111, 3'b000, 3'b001);
    rand_ops(); step("rr4", 3'b111, 3'b000, 3'b010);
    rand_ops(); step("rr5", 3'b111, 3'b000, 3'b100);

    // single requester, pointer moves to 1
    rand_ops(); step("single", 3'b001, 3'b000, 3'b001);

    // lock burst by requester 1 while others keep requesting
    for (int i = 0; i < 4; i++) begin
      rand_ops(); step("lock_burst", 3'b111, 3'b010, 3'b010, 1'b1, 1'b1);
    end
    rand_ops(); step("lock_rel",   3'b111, 3'b000, 3'b010, 1'b1, 1'b1);
    rand_ops(); step("after_rel",  3'b111, 3'b000, 3'b100);

    // lock gap: requester 2 holds lock, issues 1 of 3 cycles; 0 never granted
    rand_ops(); step("gap_enter", 3'b100, 3'b100, 3'b100);
    for (int i = 0; i < 3; i++) begin
      rand_ops(); step("gap_idle0", 3'b001, 3'b100, 3'b000, 1'b1, 1'b1);
      rand_ops(); step("gap_idle1", 3'b001, 3'b100, 3'b000, 1'b1, 1'b1);
      rand_ops(); step("gap_issue", 3'b101, 3'b100, 3'b100, 1'b1, 1'b1);
    end
    // release cycle is still restricted to the owner; other request waits
    rand_ops(); step("gap_rel",  3'b001, 3'b000, 3'b000);
    rand_ops(); step("gap_wait", 3'b001, 3'b000, 3'b001);

    // lock without request is ignored in OPEN
    step("lock_noreq", 3'b000, 3'b111, 3'b000);
    rand_ops(); step("open_again", 3'b011, 3'b000, 3'b010);
    step("drain0", 3'b000, 3'b000, 3'b000);
    step("drain1", 3'b000, 3'b000, 3'b000);
    step("unlocked", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);

    // data routing: requester 2 lane 0 = 1 * 0x1234 + 0 (pointer is at 2)
    rand_ops();
    bus.o_in[2]   = lane_set(bus.o_in[2],   0, 16'h0001);
    bus.t_in[2]   = lane_set(bus.t_in[2],   0, 16'h1234);
    bus.add_in[2] = lane_set(bus.add_in[2], 0, 16'h0000);
    step("route", 3'b100, 3'b000, 3'b100);
    chk("route_op_lane0", 512'(lane_get(bus.mul_o_out, 0)), 512'(16'h0001));
    step("route_wait", 3'b000, 3'b000, 3'b000);
    chk("route_rsp_vld",   512'(bus.rsp_valid), 512'(3'b100));
    chk("route_rsp_lane0", 512'(lane_get(bus.rsp_dat, 0)), 512'(16'h1234));
    step("route_drain", 3'b000, 3'b000, 3'b000);

    // reset mid-burst: two issues in flight are dropped
    rand_ops(); step("burst0", 3'b001, 3'b000, 3'b001);
    rand_ops(); step("burst1", 3'b001, 3'b000, 3'b001);
    rand_ops(); step("burst2", 3'b001, 3'b000, 3'b001);
    rst = 1'b1;
    q.delete();
    exp_ops = '0;
    #1;
    chk("mid_rst_gnt",  512'(bus.gnt), 512'(0));
    chk("mid_rst_ops",  512'({bus.mul_o_out, bus.mul_t_out, bus.mul_add_out}), 512'(0));
    chk("mid_rst_rsp",  512'(bus.rsp_valid), 512'(0));
    chk("mid_rst_busy", 512'(bus.busy), 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst0", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    step("post_rst1", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    rand_ops(); step("post_rst_ptr", 3'b111, 3'b000, 3'b001);
    for (int i = 0; i < 4; i++) step("final_drain", 3'b000, 3'b000, 3'b000);

    chk("scoreboard_empty", 512'(q.size()), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // hard stop in case anything stalls
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_array_arbiter.md
Name: mul_array_arbiter

Overview:
- Shares the 9-lane GF(2^m) multiplier array between NREQ requesters, for example the Goppa-polynomial evaluator, syndrome and key-equation units.
- Each cycle it selects one requester, registers that requester's o/t/add operand vectors into the array inputs, and tags the issue. It returns the array result to the owner with a valid strobe after the fixed array latency.
- Supports round-robin fairness and a lock for multi-cycle bursts.

Parameters:
- m, 16: field element width in bits.
- LANES, 9: multiplier lanes in the array.
- NREQ, 3: number of requesters, range 2..4.
- MUL_LAT, 1: cycles from a registered operand to a valid mulX_r_dat.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- req, in, NREQ: per-requester issue request, level.
- lock, in, NREQ: per-requester burst lock, sampled with req.
- o_in, in, NREQ*LANES*m: requester k operand A at slice k, lane 0 at MSB end.
- t_in, in, NREQ*LANES*m: operand B per requester.
- add_in, in, NREQ*LANES*m: accumulate addend per requester.
- gnt, out, NREQ: one-hot, combinational; issue accepted this cycle.
- busy, out, 1: lock held or issue in flight.
- mul_o_out, out, LANES*m: registered operand A to the array.
- mul_t_out, out, LANES*m: registered operand B to the array.
- mul_add_out, out, LANES*m: registered addend to the array.
- mul_r_dat, in, LANES*m: array results.
- rsp_valid, out, NREQ: one-hot, marks the owner of mul_r_dat this cycle.
- rsp_dat, out, LANES*m: mul_r_dat passed through, broadcast to all requesters.

Behaviour:
- Reset (async, rst=1):
  - owner=NONE, rr_ptr=0.
  - Tag pipeline cleared.
  - All mul_* outputs 0; rsp_valid=0; busy=0.
  - An issue in flight during reset is dropped; no rsp_valid is produced for it.
- State machine, two states:
  - OPEN: arbitrate among all asserted req.
  - LOCKED(k): only requester k is eligible; gnt to others stays 0 even if they request.
- Arbitration in OPEN:
  - Round-robin starting at rr_ptr; the first k with req[k]=1 wins.
  - gnt[k]=1 in the same cycle.
  - At the edge, rr_ptr <= (k+1) mod NREQ.
- Lock transitions:
  - Grant with lock[k]=1 moves OPEN -> LOCKED(k).
  - In LOCKED(k), a cycle with lock[k]=0 returns to OPEN at the edge; that cycle's arbitration is still restricted to k.
  - In LOCKED(k) with req[k]=0 and lock[k]=1, no issue occurs and the lock is held (gap cycles allowed, as in the evaluator's 3-cycle loop).
  - rr_ptr does not advance in LOCKED; it advances to k+1 on release.
- Issue (cycle t, gnt[k]=1):
  - At edge t+1, mul_o/t/add_out <= slice k of o_in/t_in/add_in.
  - Cycles with no grant load 0 into all three operand registers.
- Response:
  - rsp_valid[k]=1 exactly in cycle t+1+MUL_LAT.
  - rsp_dat equals mul_r_dat in that same cycle.
  - Back-to-back issues produce back-to-back responses in issue order; there is no reordering and no backpressure. Requesters must consume rsp in the cycle it is valid.
- Tag pipeline:
  - Shift register of depth 1+MUL_LAT, NREQ bits wide, one-hot or zero per stage.
  - Implementation choice: either a separate tag pipeline or the existing operand register as the first stage followed by MUL_LAT stages. Whichever is chosen, total issue-to-rsp latency is 1+MUL_LAT.
- busy = (state==LOCKED) | (any tag stage nonzero).
- Boundary conditions:
  - All req low in OPEN: no gnt, operands 0, rr_ptr unchanged.
  - Single requester: granted every cycle it requests.
  - Lock released and a different request in the same cycle: that request waits one cycle.
  - lock asserted without req: ignored in OPEN.
- Width rules:
  - Lane i of a requester's vector occupies bits [i*m +: m] counted from the MSB end, matching lane numbering mul1..mul9 = lane 0..8.
  - rsp_dat lanes are ordered the same way.

Decomposition:
- Shared package gf_mul_pkg: m, LANES, MUL_LAT, lane slice function, lane_vec_t typedef (LANES*m), req_id_t.
- Sub-module rr_arbiter (NREQ-wide round-robin with mask input for LOCKED restriction).
- Tag pipeline and operand registers live in the top.

Test Plan:
- Reset mid-burst: req[0]=1 issuing, rst pulse for 1 cycle -> all outputs 0 immediately; no rsp_valid for the two in-flight issues; rr_ptr=0 afterwards.
- Round-robin: req=3'b111 for 6 cycles, no lock -> gnt sequence 001,010,100,001,010,100; rsp_valid follows the same sequence delayed 2 cycles (MUL_LAT=1).
- Lock burst: req[1]=lock[1]=1 for 4 cycles while req[0]=req[2]=1 -> gnt=010 for all 4 cycles; lock[1]=0 on cycle 5 -> cycle 5 gnt=010; cycle 6 gnt=100.
- Lock gap: LOCKED(2), req[2] high 1 of every 3 cycles with lock[2] held, req[0]=1 throughout -> gnt[0] never asserted; operands are 0 in gap cycles.
- Data routing: requester 2 lane 0 o=16'h0001, t=16'h1234, add=0; array model returns o*t -> mul_o_out lane0=16'h0001 one cycle after gnt; rsp_dat lane0=16'h1234 with rsp_valid=100 at t+2.
- Idle: req=0 for 10 cycles -> gnt=0, busy=0, all mul_* outputs 0, rr_ptr unchanged.
